reversible_cipher_engine: RTL and testbench

REVERSIBLE_CIPHER_ENGINE -- requirements
Module: reversible_cipher_engine

---
 rtl/reversible_cipher_engine_pkg.sv | 16 +
 rtl/reversible_cipher_engine_round.sv | 45 ++++
 rtl/reversible_cipher_engine.sv | 135 +++++++++++++
 tb/tb_reversible_cipher_engine.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reversible_cipher_engine_pkg.sv
// Shared definitions for the reversible cipher engine.
//   state_t  : controller states (IDLE, RUN, DONE)
//   MODE_ENC : in_mode value selecting encryption
//   MODE_DEC : in_mode value selecting decryption
package reversible_cipher_engine_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/reversible_cipher_engine_round.sv
// One combinational cipher round, forward or inverse.
//   x    : round input word
//   k_r  : round key (already rotated for this round)
//   mode : MODE_ENC applies the forward round, MODE_DEC its exact inverse
//   y    : round output word
// Forward : x ^= k_r ; rotl 1 ; lower half ^= upper half
// Inverse : lower half ^= upper half ; rotr 1 ; x ^= k_r
module reversible_round
    import reversible_cipher_engine_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] k_r,
    input  logic             mode,
    output logic [WIDTH-1:0] y
);

    localparam int H = WIDTH / 2;

    logic [WIDTH-1:0] enc_keyed;
    logic [WIDTH-1:0] enc_rot;
    logic [WIDTH-1:0] enc_mix;
    logic [WIDTH-1:0] dec_mix;
    logic [WIDTH-1:0] dec_rot;
    logic [WIDTH-1:0] dec_keyed;

    assign enc_keyed = x ^ k_r;
    assign enc_rot   = {enc_keyed[WIDTH-2:0], enc_keyed[WIDTH-1]};

    // The Feynman (CNOT) stage is its own inverse: the upper half passes
    // through untouched, so XOR-ing it into the lower half again undoes it.
    for (genvar gi = 0; gi < H; gi++) begin : g_feynman
        assign enc_mix[gi]     = enc_rot[gi] ^ enc_rot[gi+H];
        assign enc_mix[gi+H]   = enc_rot[gi+H];
        assign dec_mix[gi]     = x[gi] ^ x[gi+H];
        assign dec_mix[gi+H]   = x[gi+H];
    end

    assign dec_rot   = {dec_mix[0], dec_mix[WIDTH-1:1]};
    assign dec_keyed = dec_rot ^ k_r;

    assign y = (mode == MODE_DEC) ? dec_keyed : enc_mix;

endmodule

// File: rtl/reversible_cipher_engine.sv
// Iterative reversible block cipher: accepts one word, applies ROUNDS rounds
// (one per clock), then presents the result until the consumer takes it.
//   clk, rst            : clock and synchronous active-high reset
//   in_valid/in_ready   : input handshake; in_ready only while idle
//   in_data/in_key      : plaintext or ciphertext word, and key
//   in_mode             : 0 = encrypt, 1 = decrypt
//   out_valid/out_ready : output handshake; out_valid only when done
//   out_data            : result word, 0 whenever no result is offered
//   busy                : high while running or holding a result
module reversible_cipher_engine
    import reversible_cipher_engine_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ROUNDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_key,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int CW = $clog2(ROUNDS + 1);
    localparam int AW = $clog2(WIDTH);

    state_t           state_reg;
    logic [CW-1:0]    c_reg;
    logic [WIDTH-1:0] x_reg;
    logic [WIDTH-1:0] key_reg;
    logic             mode_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             busy_reg;

    logic [WIDTH-1:0] rot_keys [WIDTH];
    logic [31:0]      r_idx;
    logic [AW-1:0]    r_mod;
    logic [WIDTH-1:0] k_r;
    logic [WIDTH-1:0] round_next;
    logic             last_round;

    // Every rotation of the latched key; the round index picks one.
    // For gi = 0 the right shift by WIDTH contributes nothing.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rot_key
        assign rot_keys[gi] = (key_reg << gi) | (key_reg >> (WIDTH - gi));
    end

    // Decryption walks the round keys backwards so each inverse round
    // meets the key its forward round used.
    always_comb begin
        r_idx = (mode_reg == MODE_DEC) ? (32'(ROUNDS) - 32'd1 - 32'(c_reg))
                                       : 32'(c_reg);
        r_mod = AW'(r_idx % 32'(WIDTH));
        k_r   = rot_keys[r_mod];
    end

    assign last_round = (c_reg == CW'(ROUNDS - 1));

    reversible_round #(
        .WIDTH (WIDTH)
    ) u_round (
        .x    (x_reg),
        .k_r  (k_r),
        .mode (mode_reg),
        .y    (round_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            c_reg         <= '0;
            x_reg         <= '0;
            key_reg       <= '0;
            mode_reg      <= MODE_ENC;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        x_reg        <= in_data;
                        key_reg      <= in_key;
                        mode_reg     <= in_mode;
                        c_reg        <= '0;
                        state_reg    <= RUN;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                RUN: begin
                    x_reg <= round_next;
                    c_reg <= c_reg + 1'b1;
                    if (last_round) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= round_next;
                    end
                end
                DONE: begin
                    // Return to IDLE only; acceptance of the next word
                    // happens no earlier than the following edge.
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        out_data_reg  <= '0;
                        busy_reg      <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    out_data_reg  <= '0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_reversible_cipher_engine.sv
// Self-checking bench: a default (8-bit, 4-round) engine checked every cycle
// against a transaction-level model, plus a 1-round engine for hand vectors.
module tb_reversible_cipher_engine;

    localparam int R = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_mode, out_valid, out_ready, busy;
    logic [7:0] in_data, in_key, out_data;
    logic       s_in_valid, s_in_ready, s_in_mode, s_out_valid, s_out_ready, s_busy;
    logic [7:0] s_in_data, s_in_key, s_out_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reversible_cipher_engine #(.WIDTH(8), .ROUNDS(R)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_key(in_key), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    reversible_cipher_engine #(.WIDTH(8), .ROUNDS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .in_key(s_in_key), .in_mode(s_in_mode),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .busy(s_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Whole-word model using integer arithmetic on the round rules.
    function automatic int rotl8(input int v, input int n);
        return ((v << n) | (v >> (8 - n))) & 255;
    endfunction

    function automatic logic [7:0] model(input logic [7:0] d, input logic [7:0] k,
                                         input logic dec, input int rounds);
        int x = int'(d);
        for (int i = 0; i < rounds; i++) begin
            int r  = dec ? rounds - 1 - i : i;
            int kr = rotl8(int'(k), r % 8);
            if (!dec) begin
                x = x ^ kr;
                x = rotl8(x, 1);
                x = x ^ ((x >> 4) & 15);
            end else begin
                x = x ^ ((x >> 4) & 15);
                x = ((x >> 1) | ((x & 1) << 7)) & 255;
                x = x ^ kr;
            end
        end
        return 8'(x);
    endfunction

    // ---------------- per-cycle checker for the default engine -------------
    int         cyc = 0;
    bit         chk_en = 0;
    bit         job = 0;
    int         acc_cyc = 0;
    logic [7:0] job_exp = 0;
    int         acc_q[$];
    logic [7:0] ex_q[$];
    logic [7:0] dl_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (chk_en) begin
            bit         ev;
            logic [7:0] ed;
            ev = job && (cyc - acc_cyc >= R + 1);
            ed = ev ? job_exp : 8'h00;
            chk("in_ready", 32'(in_ready), 32'(!job));
            chk("busy", 32'(busy), 32'(job));
            chk("out_valid", 32'(out_valid), 32'(ev));
            chk("out_data", 32'(out_data), 32'(ed));
            if (rst) begin
                job = 0;
            end else if (ev && out_ready) begin
                dl_q.push_back(out_data);
                job = 0;
            end else if (!job && in_valid) begin
                job     = 1;
                acc_cyc = cyc;
                job_exp = model(in_data, in_key, in_mode, R);
                acc_q.push_back(cyc);
                ex_q.push_back(job_exp);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start(input logic [7:0] d, input logic [7:0] k, input logic m);
        int n = 0;
        in_data = d; in_key = k; in_mode = m; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'(1), 32'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data = 8'($urandom);
        in_key = 8'($urandom);
        in_mode = 1'($urandom);
    endtask

    task automatic wait_ov(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 50);
        if (lat >= 50) chk("out_valid_timeout", 32'(1), 32'(0));
    endtask

    task automatic xact(input logic [7:0] d, input logic [7:0] k, input logic m,
                        output logic [7:0] res, output int lat);
        start(d, k, m);
        wait_ov(lat);
        res = out_data;
        @(posedge clk); #1;
    endtask

    task automatic xact1(input logic [7:0] d, input logic [7:0] k, input logic m,
                         output logic [7:0] res, output int lat);
        s_in_data = d; s_in_key = k; s_in_mode = m; s_in_valid = 1'b1;
        @(negedge clk);
        if (!s_in_ready) chk("r1_in_ready", 32'(s_in_ready), 32'(1));
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        s_in_data = 8'h00;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!s_out_valid && lat < 20);
        res = s_out_data;
        @(posedge clk); #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] res, ct, v0;
        int         lat;

        rst = 1'b1; in_valid = 0; in_data = 0; in_key = 0; in_mode = 0; out_ready = 1'b1;
        s_in_valid = 0; s_in_data = 0; s_in_key = 0; s_in_mode = 0; s_out_ready = 1'b1;
        @(posedge clk); #1;
        chk_en = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        @(posedge clk); #1;

        // Hand-computed vectors pinning the model itself.
        chk("model_d2_k00", 32'(model(8'hD2, 8'h00, 1'b0, 1)), 32'h AF);
        chk("model_d2_kf1", 32'(model(8'hD2, 8'hF1, 1'b0, 1)), 32'h42);
        chk("model_42_dec", 32'(model(8'h42, 8'hF1, 1'b1, 1)), 32'hD2);

        // One-round engine: hand vectors and latency 2.
        xact1(8'hD2, 8'h00, 1'b0, res, lat);
        chk("r1_enc_k00", 32'(res), 32'hAF);
        chk("r1_lat", 32'(lat), 32'd2);
        xact1(8'hD2, 8'hF1, 1'b0, res, lat);
        chk("r1_enc_kf1", 32'(res), 32'h42);
        xact1(8'h42, 8'hF1, 1'b1, res, lat);
        chk("r1_dec_kf1", 32'(res), 32'hD2);
        chk("r1_dec_lat", 32'(lat), 32'd2);

        // Round trips with random data/key on the default engine.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] d, k;
            d = 8'($urandom);
            k = 8'($urandom);
            xact(d, k, 1'b0, ct, lat);
            chk("enc_lat", 32'(lat), 32'(R + 1));
            xact(ct, k, 1'b1, res, lat);
            chk("dec_lat", 32'(lat), 32'(R + 1));
            chk("roundtrip", 32'(res), 32'(d));
        end

        // Backpressure: result held for 3 cycles, new input ignored.
        out_ready = 1'b0;
        start(8'h5A, 8'h3C, 1'b0);
        wait_ov(lat);
        v0 = out_data;
        chk("bp_value", 32'(v0), 32'(model(8'h5A, 8'h3C, 1'b0, R)));
        #1 in_valid = 1'b1; in_data = 8'hEE;
        repeat (3) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'(1));
            chk("bp_out_data", 32'(out_data), 32'(v0));
            chk("bp_in_ready", 32'(in_ready), 32'(0));
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Abort: reset during the run at c = 2.
        start(8'h77, 8'h19, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 32'(in_ready), 32'(1));
        chk("abort_out_valid", 32'(out_valid), 32'(0));
        @(posedge clk); #1;
        xact(8'h77, 8'h19, 1'b0, res, lat);
        chk("abort_fresh", 32'(res), 32'(model(8'h77, 8'h19, 1'b0, R)));
        chk("abort_fresh_lat", 32'(lat), 32'(R + 1));

        // Streaming: in_valid held high with out_ready=1.
        acc_q.delete(); ex_q.delete(); dl_q.delete();
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            in_data = 8'(i * 37 + 5);
            in_key = 8'(i * 11);
            in_mode = 1'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("stream_accepts", 32'(acc_q.size()), 32'd10);
        for (int i = 1; i < acc_q.size(); i++)
            chk("stream_spacing", 32'(acc_q[i] - acc_q[i-1]), 32'(R + 2));
        chk("stream_delivered", 32'(dl_q.size()), 32'(ex_q.size()));
        for (int i = 0; i < dl_q.size() && i < ex_q.size(); i++)
            chk("stream_word", 32'(dl_q[i]), 32'(ex_q[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
